// File: rtl/led_mmio_port.sv
// Memory-mapped LED port: 16-byte register window, blink divider and registered pin drive.
// Optional LED_PWM_EN adds a 4-bit brightness PWM and the PWM_DUTY register at offset 0xC.
module led_mmio_port #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          BLINK_DIV = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic [7:0]  led
);

    localparam logic [1:0]           SEL_LED    = 2'd0;
    localparam logic [1:0]           SEL_MASK   = 2'd1;
    localparam logic [1:0]           SEL_RELOAD = 2'd2;
    localparam logic [1:0]           SEL_DUTY   = 2'd3;
    localparam logic [BLINK_DIV-1:0] PRE_ONE    = BLINK_DIV'(1);

    logic                 hit, wr, rd, tick;
    logic [1:0]           sel;
    logic [31:0]          rd_mux;
    logic [7:0]           pattern;

    logic [7:0]           led_out_q, led_out_d;
    logic [7:0]           blink_mask_q, blink_mask_d;
    logic [15:0]          blink_reload_q, blink_reload_d;
    logic [BLINK_DIV-1:0] pre_q, pre_d;
    logic [15:0]          bdiv_q, bdiv_d;
    logic                 phase_q, phase_d;
    logic [7:0]           led_q, led_d;
    logic [31:0]          bus_rdata_q, bus_rdata_d;
    logic                 bus_ready_q, bus_ready_d;
`ifdef LED_PWM_EN
    logic [3:0]           pwm_duty_q, pwm_duty_d;
    logic [3:0]           pwm_cnt_q, pwm_cnt_d;
`endif

    // Upper store-data bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:16];

    always_comb begin
        hit  = (bus_addr[31:4] == BASE_ADDR[31:4]) && (bus_addr[1:0] == 2'b00);
        wr   = hit && bus_we;
        rd   = hit && bus_re;
        sel  = bus_addr[3:2];
        tick = &pre_q;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (sel)
            SEL_LED:    rd_mux = {24'd0, led_out_q};
            SEL_MASK:   rd_mux = {24'd0, blink_mask_q};
            SEL_RELOAD: rd_mux = {16'd0, blink_reload_q};
`ifdef LED_PWM_EN
            SEL_DUTY:   rd_mux = {28'd0, pwm_duty_q};
`endif
            default:    rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        led_out_d      = led_out_q;
        blink_mask_d   = blink_mask_q;
        blink_reload_d = blink_reload_q;
`ifdef LED_PWM_EN
        pwm_duty_d     = pwm_duty_q;
        pwm_cnt_d      = pwm_cnt_q + 4'd1;
`endif
        if (wr) begin
            case (sel)
                SEL_LED:    led_out_d      = bus_wdata[7:0];
                SEL_MASK:   blink_mask_d   = bus_wdata[7:0];
                SEL_RELOAD: blink_reload_d = bus_wdata[15:0];
`ifdef LED_PWM_EN
                SEL_DUTY:   pwm_duty_d     = bus_wdata[3:0];
`endif
                default:    ;
            endcase
        end
    end

    // Blink divider; a reload write restarts the whole chain in a known phase.
    always_comb begin
        pre_d   = pre_q + PRE_ONE;
        bdiv_d  = bdiv_q;
        phase_d = phase_q;
        if (tick) begin
            if (bdiv_q == 16'd0) begin
                if (blink_reload_q == 16'd0) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = ~phase_q;
                    bdiv_d  = blink_reload_q;
                end
            end else begin
                bdiv_d = bdiv_q - 16'd1;
            end
        end
        if (wr && (sel == SEL_RELOAD)) begin
            phase_d = 1'b1;
            bdiv_d  = bus_wdata[15:0];
            pre_d   = '0;
        end
    end

    always_comb begin
        pattern = led_out_q & (~blink_mask_q | {8{phase_q}});
`ifdef LED_PWM_EN
        led_d   = pattern & {8{pwm_cnt_q < pwm_duty_q}};
`else
        led_d   = pattern;
`endif
        bus_ready_d = wr || rd;
        bus_rdata_d = rd ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_out_q      <= 8'd0;
            blink_mask_q   <= 8'd0;
            blink_reload_q <= 16'd0;
            pre_q          <= '0;
            bdiv_q         <= 16'd0;
            phase_q        <= 1'b1;
            led_q          <= 8'd0;
            bus_rdata_q    <= 32'd0;
            bus_ready_q    <= 1'b0;
`ifdef LED_PWM_EN
            pwm_duty_q     <= 4'hF;
            pwm_cnt_q      <= 4'd0;
`endif
        end else begin
            led_out_q      <= led_out_d;
            blink_mask_q   <= blink_mask_d;
            blink_reload_q <= blink_reload_d;
            pre_q          <= pre_d;
            bdiv_q         <= bdiv_d;
            phase_q        <= phase_d;
            led_q          <= led_d;
            bus_rdata_q    <= bus_rdata_d;
            bus_ready_q    <= bus_ready_d;
`ifdef LED_PWM_EN
            pwm_duty_q     <= pwm_duty_d;
            pwm_cnt_q      <= pwm_cnt_d;
`endif
        end
    end

    assign bus_rdata = bus_rdata_q;
    assign bus_ready = bus_ready_q;
    assign led       = led_q;

endmodule

// File: tb/tb_led_mmio_port.sv
// Bench for led_mmio_port: directed scenarios plus random bus traffic against a cycle-count model.
// Define LED_PWM_EN for both files to cover the PWM build.
module tb_led_mmio_port;

    localparam logic [31:0] BASE      = 32'hFFFF_0000;
    localparam int          BLINK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bus_addr = 32'd0;
    logic [31:0] bus_wdata = 32'd0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [7:0]  led;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: architectural registers plus edge counts since the last restart points.
    logic [7:0]  m_led_out, m_mask, m_exp_led;
    logic [15:0] m_reload;
    logic [3:0]  m_duty;
    int          m_k, m_pwm;
    logic [31:0] m_exp_rdata;
    logic        m_exp_rdy;

    led_mmio_port #(.BASE_ADDR(BASE), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phase after k edges since the last restart: one tick per 2^BLINK_DIV edges,
    // one toggle per (R+1) ticks, starting from phase 1.
    function automatic logic phase_of(input int k, input logic [15:0] r);
        int ticks;
        if (r == 16'd0) return 1'b1;
        ticks = k / (1 << BLINK_DIV);
        return ((ticks / (int'(r) + 1)) % 2) == 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0: return {24'd0, m_led_out};
            2'd1: return {24'd0, m_mask};
            2'd2: return {16'd0, m_reload};
`ifdef LED_PWM_EN
            default: return {28'd0, m_duty};
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    task automatic model_edge();
        logic       hit, ph;
        logic [7:0] pat;
        logic [1:0] off;
        if (!rst_n) begin
            m_led_out = 8'd0; m_mask = 8'd0; m_reload = 16'd0; m_duty = 4'hF;
            m_k = 0; m_pwm = 0;
            m_exp_led = 8'd0; m_exp_rdy = 1'b0; m_exp_rdata = 32'd0;
            return;
        end
        hit = (bus_addr[31:4] == BASE[31:4]) && (bus_addr[1:0] == 2'b00);
        off = bus_addr[3:2];
        ph  = phase_of(m_k, m_reload);
        pat = m_led_out & (~m_mask | {8{ph}});
`ifdef LED_PWM_EN
        m_exp_led = ((m_pwm % 16) < int'(m_duty)) ? pat : 8'd0;
`else
        m_exp_led = pat;
`endif
        m_exp_rdy   = hit && (bus_we || bus_re);
        m_exp_rdata = (hit && bus_re) ? model_read(off) : 32'd0;
        m_k++;
        m_pwm++;
        if (hit && bus_we) begin
            case (off)
                2'd0: m_led_out = bus_wdata[7:0];
                2'd1: m_mask    = bus_wdata[7:0];
                2'd2: begin m_reload = bus_wdata[15:0]; m_k = 0; end
                default: begin
`ifdef LED_PWM_EN
                    m_duty = bus_wdata[3:0];
`endif
                end
            endcase
        end
    endtask

    task automatic step(input logic rn, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic r);
        @(negedge clk);
        rst_n = rn; bus_addr = a; bus_wdata = d; bus_we = w; bus_re = r;
        @(posedge clk);
        model_edge();
        #1;
        check_eq("led", {24'd0, led}, {24'd0, m_exp_led});
        check_eq("ready", {31'd0, bus_ready}, {31'd0, m_exp_rdy});
        check_eq("rdata", bus_rdata, m_exp_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [31:0] d);
        step(1'b1, BASE + {28'd0, off}, d, 1'b1, 1'b0);
    endtask

    task automatic rd_reg(input logic [3:0] off);
        step(1'b1, BASE + {28'd0, off}, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] a, d;
        logic        w, r, rn;

        // Reset and readback of the reset values.
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rd_reg(4'h0); rd_reg(4'h4); rd_reg(4'h8); rd_reg(4'hC);

        // Basic write, led latency, readback.
        wr_reg(4'h0, 32'h0000_00A5);
        idle(2);
        rd_reg(4'h0);
        idle(1);

        // Blinking with reload 1, then frozen with reload 0.
        wr_reg(4'h0, 32'hFFFF_FFFF);
        wr_reg(4'h4, 32'h0000_000F);
        wr_reg(4'h8, 32'h0000_0001);
        idle(40);
        wr_reg(4'h8, 32'h0000_0000);
        idle(20);

        // Misses: outside window and misaligned.
        wr_reg(4'h0, 32'h0000_005A);
        step(1'b1, BASE + 32'h10, 32'h0000_0000, 1'b1, 1'b0);
        step(1'b1, BASE + 32'h2, 32'h0000_0000, 1'b1, 1'b1);
        step(1'b1, BASE - 32'h4, 32'h0000_0000, 1'b0, 1'b1);
        rd_reg(4'h0);

        // Simultaneous read/write returns the old value, back-to-back accesses.
        wr_reg(4'h4, 32'h0000_0011);
        step(1'b1, BASE + 32'h4, 32'h0000_0033, 1'b1, 1'b1);
        rd_reg(4'h4);
        rd_reg(4'h0);
        wr_reg(4'hC, 32'h0000_0007);
        rd_reg(4'hC);

        // Reset while in blink phase 0, with an access in flight.
        wr_reg(4'h0, 32'h0000_00FF);
        wr_reg(4'h4, 32'h0000_00FF);
        wr_reg(4'h8, 32'h0000_0001);
        idle(10);
        step(1'b0, BASE, 32'h0000_0012, 1'b1, 1'b1);
        rd_reg(4'h0); rd_reg(4'h4); rd_reg(4'h8);
        idle(2);

`ifdef LED_PWM_EN
        wr_reg(4'h0, 32'h0000_0001);
        wr_reg(4'hC, 32'h0000_0004);
        idle(34);
        wr_reg(4'hC, 32'h0000_0000);
        idle(20);
        wr_reg(4'hC, 32'h0000_000F);
        idle(20);
`endif

        // Random traffic around the window.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = BASE + (32'($urandom_range(0, 3)) << 2);
                6:       a = BASE + 32'($urandom_range(0, 3) * 4 + $urandom_range(1, 3));
                7:       a = BASE + 32'h10;
                8:       a = BASE - 32'h4;
                default: a = $urandom;
            endcase
            d = $urandom;
            if (a == BASE + 32'h8) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
            w  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 199) != 0);
            step(rn, a, d, w, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_mmio_port.md
# led_mmio_port

Memory-mapped LED output port sitting directly downstream of the CPU datapath's load/store unit. Decodes single-cycle bus reads and writes inside a 16-byte window, holds the LED pattern, blink mask and blink rate, and drives the board's `led[7:0]` pins. The pins are registered, and an optional per-LED blink runs off an internal prescaler. This block replaces direct LED wiring inside `top`.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: byte address of register offset 0x0. Aligned to 16 bytes.
- `BLINK_DIV`, 20: prescaler width. One blink tick every 2^BLINK_DIV cycles. Set to 2 in simulation.
- `clk`  in  1: system clock; all state is on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `bus_addr`  in  32: byte address from the datapath.
- `bus_wdata`  in  32: store data.
- `bus_we`  in  1: write strobe, one cycle per access.
- `bus_re`  in  1: read strobe, one cycle per access.
- `bus_rdata`  out  32: read data, registered.
- `bus_ready`  out  1: one-cycle acknowledge of any access to the window.
- `led`  out  8: registered LED drive, 1 = on.

## Operation
- Hit: `bus_addr[31:4] == BASE_ADDR[31:4]` and `bus_addr[1:0] == 0`. A misaligned address or an address outside the window is a miss.
- Registers, selected by `bus_addr[3:2]`:
  - 0x0 `LED_OUT[7:0]`
  - 0x4 `BLINK_MASK[7:0]`
  - 0x8 `BLINK_RELOAD[15:0]`
  - 0xC `PWM_DUTY[3:0]` (only when the macro is defined; otherwise reserved)
- Writes use `bus_wdata` low bits and ignore upper bits. Reads zero-extend. A read of a reserved register returns 0.
- Prescaler: free-running `BLINK_DIV`-bit counter. `tick` is high in the cycle it equals all-ones, then it wraps to 0.
- Blink divider: 16-bit down-counter `bdiv` and a 1-bit `phase`.
  - On `tick`: if `bdiv == 0`, toggle `phase` and load `bdiv = BLINK_RELOAD`. Otherwise decrement `bdiv`.
  - When `BLINK_RELOAD == 0`, the phase is frozen at 1 and there is no toggling.
  - A write to `BLINK_RELOAD` sets `phase = 1`, loads `bdiv` with the new value, and clears the prescaler, all in the same edge.
- LED function: `pattern = LED_OUT & (~BLINK_MASK | {8{phase}})`. `led` takes `pattern` (gated per Configuration) on the next edge.
- Accesses from the datapath never stall. `bus_ready` is generated for every hit and is never generated for a miss.

## Timing
- Reset values: all registers 0, prescaler 0, `bdiv` 0, `phase` 1, `led` 0, `bus_rdata` 0, `bus_ready` 0.
- Write at edge N:
  - The register holds the new value after edge N.
  - `led` reflects it after edge N+1.
  - `bus_ready` is high for the cycle following edge N.
- Read at edge N: `bus_rdata` and `bus_ready` are valid after edge N, for one cycle.
- After that cycle, `bus_rdata` returns to 0 unless another read hit occurs.
- `bus_we` and `bus_re` both high: the write is performed. `bus_rdata` returns the pre-write value, and there is a single `bus_ready` pulse.
- A miss produces no register change, `bus_rdata` = 0 and `bus_ready` = 0.
- `rst_n` low at any edge (including during a blink or an access) forces all reset values at that edge. The access is dropped without `bus_ready`.
- Back-to-back accesses on consecutive cycles are all accepted. Each produces its own `bus_ready` pulse.

## Configuration
- `LED_PWM_EN` defined:
  - A 4-bit free-running `pwm_cnt` is added, plus register 0xC.
  - The drive is `led <= pattern & {8{pwm_cnt < PWM_DUTY}}`.
  - `PWM_DUTY = 0` means all LEDs off. `PWM_DUTY = 15` gives 15/16 duty.
  - `PWM_DUTY` resets to 4'hF.
- Not defined:
  - `led <= pattern`.
  - Offset 0xC reads 0, and writes to it are ignored (`bus_ready` is still pulsed).

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges. Expect `led` = 0x00, `bus_ready` = 0, and readback of 0x0/0x4/0x8 = 0.
- Write 0x0 := 0x0000_00A5. Expect `bus_ready` 1 cycle, `led` = 0xA5 two edges after the write, and a read of 0x0 returning 0x0000_00A5 with 1-cycle latency.
- Blink (`BLINK_DIV` = 2): `LED_OUT` = 0xFF, `BLINK_MASK` = 0x0F, `BLINK_RELOAD` = 1. Expect `led` to alternate 0xFF / 0xF0, toggling every 8 cycles. With `BLINK_RELOAD` = 0, `led` stays at 0xFF.
- Misses:
  - Write to `BASE_ADDR + 0x10` or `BASE_ADDR + 0x2`: no `bus_ready`, `LED_OUT` unchanged.
  - Simultaneous re/we to 0x4 with 0x33 when it holds 0x11: `bus_rdata` = 0x11, then a read returns 0x33.
- Reset mid-blink: assert `rst_n` low during phase 0. Expect `led` = 0 at that edge and all registers 0 afterwards.
- With `LED_PWM_EN`: `LED_OUT` = 0x01, `PWM_DUTY` = 4. Expect `led[0]` high for exactly 4 of every 16 cycles. With `PWM_DUTY` = 0, `led[0]` is never high.
